// File: rtl/modport_counter_if.sv
// Bus bundle for the 16-bit up/down counter: load/mode/data controls in, count out.
// The controller side takes the master modport and the counter takes the slave modport.
interface modport_counter_if;
    logic [15:0] data_in;
    logic        load;
    logic        mode;
    logic [15:0] data_out;

    modport master (
        output data_in,
        output load,
        output mode,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  load,
        input  mode,
        output data_out
    );
endinterface

// File: rtl/modport_counter.sv
// 16-bit loadable up/down counter. Load beats count, reset clears asynchronously,
// and the output comes straight from the count register.
module modport_counter (
    input  logic               clk,
    input  logic               reset,
    modport_counter_if.slave   bus
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // There is no hold state: with load low the counter steps every cycle in the mode direction.
    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = bus.data_in;
        end else if (bus.mode) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.data_out = count_q;

endmodule

// File: tb/tb_modport_counter.sv
// Directed bench for modport_counter: reset, count, load, wrap, priority and async reset cases.
module tb_modport_counter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    modport_counter_if bus ();

    modport_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so they are stable well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.load     = 1'b1;
        bus.mode     = 1'b1;
        bus.data_in  = 16'hFFFF;
        #2;
        n_checks++;
        if (bus.data_out !== 16'h0000) begin
            $display("FAIL reset_initial: got %h expected %h", bus.data_out, 16'h0000);
            n_errors++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.data_out !== 16'h0000) begin
                $display("FAIL reset_hold%0d: got %h expected %h", i, bus.data_out, 16'h0000);
                n_errors++;
            end
        end
        bus.load = 1'b0;
        bus.mode = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.data_out !== 16'h0000) begin
            $display("FAIL reset_release_noedge: got %h expected %h", bus.data_out, 16'h0000);
            n_errors++;
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (bus.data_out !== 16'(i)) begin
                $display("FAIL count_up%0d: got %h expected %h", i, bus.data_out, 16'(i));
                n_errors++;
            end
        end
    endtask

    task automatic test_load();
        bus.load    = 1'b1;
        bus.data_in = 16'h1234;
        step();
        n_checks++;
        if (bus.data_out !== 16'h1234) begin
            $display("FAIL load_value: got %h expected %h", bus.data_out, 16'h1234);
            n_errors++;
        end
        bus.load = 1'b0;
        bus.mode = 1'b0;
        step();
        n_checks++;
        if (bus.data_out !== 16'h1233) begin
            $display("FAIL load_down1: got %h expected %h", bus.data_out, 16'h1233);
            n_errors++;
        end
        step();
        n_checks++;
        if (bus.data_out !== 16'h1232) begin
            $display("FAIL load_down2: got %h expected %h", bus.data_out, 16'h1232);
            n_errors++;
        end
    endtask

    task automatic test_wrap_up();
        bus.load    = 1'b1;
        bus.mode    = 1'b0;
        bus.data_in = 16'hFFFE;
        step();
        bus.load = 1'b0;
        bus.mode = 1'b1;
        step();
        n_checks++;
        if (bus.data_out !== 16'hFFFF) begin
            $display("FAIL wrap_up1: got %h expected %h", bus.data_out, 16'hFFFF);
            n_errors++;
        end
        step();
        n_checks++;
        if (bus.data_out !== 16'h0000) begin
            $display("FAIL wrap_up2: got %h expected %h", bus.data_out, 16'h0000);
            n_errors++;
        end
    endtask

    task automatic test_wrap_down();
        bus.load    = 1'b1;
        bus.mode    = 1'b1;
        bus.data_in = 16'h0001;
        step();
        bus.load = 1'b0;
        bus.mode = 1'b0;
        step();
        n_checks++;
        if (bus.data_out !== 16'h0000) begin
            $display("FAIL wrap_down1: got %h expected %h", bus.data_out, 16'h0000);
            n_errors++;
        end
        step();
        n_checks++;
        if (bus.data_out !== 16'hFFFF) begin
            $display("FAIL wrap_down2: got %h expected %h", bus.data_out, 16'hFFFF);
            n_errors++;
        end
    endtask

    task automatic test_load_priority();
        bus.load    = 1'b0;
        bus.mode    = 1'b1;
        step();
        bus.load    = 1'b1;
        bus.mode    = 1'b1;
        bus.data_in = 16'h00A0;
        step();
        n_checks++;
        if (bus.data_out !== 16'h00A0) begin
            $display("FAIL load_priority: got %h expected %h", bus.data_out, 16'h00A0);
            n_errors++;
        end
    endtask

    task automatic test_mode_switch();
        logic [15:0] exp_seq [4];
        logic        mode_seq [4];
        exp_seq[0] = 16'h0101; mode_seq[0] = 1'b1;
        exp_seq[1] = 16'h0100; mode_seq[1] = 1'b0;
        exp_seq[2] = 16'h0101; mode_seq[2] = 1'b1;
        exp_seq[3] = 16'h0102; mode_seq[3] = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 16'h0100;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mode = mode_seq[i];
            step();
            n_checks++;
            if (bus.data_out !== exp_seq[i]) begin
                $display("FAIL mode_switch%0d: got %h expected %h", i, bus.data_out, exp_seq[i]);
                n_errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        bus.load    = 1'b1;
        bus.mode    = 1'b1;
        bus.data_in = 16'h5554;
        step();
        bus.load = 1'b0;
        step();
        n_checks++;
        if (bus.data_out !== 16'h5555) begin
            $display("FAIL async_pre: got %h expected %h", bus.data_out, 16'h5555);
            n_errors++;
        end
        // Present a load that would be captured at the next edge, then reset between edges.
        bus.load    = 1'b1;
        bus.data_in = 16'hBEEF;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.data_out !== 16'h0000) begin
            $display("FAIL async_clear: got %h expected %h", bus.data_out, 16'h0000);
            n_errors++;
        end
        step();
        n_checks++;
        if (bus.data_out !== 16'h0000) begin
            $display("FAIL async_hold: got %h expected %h", bus.data_out, 16'h0000);
            n_errors++;
        end
        bus.load = 1'b0;
        bus.mode = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.data_out !== 16'h0000) begin
            $display("FAIL async_release: got %h expected %h", bus.data_out, 16'h0000);
            n_errors++;
        end
        step();
        n_checks++;
        if (bus.data_out !== 16'h0001) begin
            $display("FAIL async_first_edge: got %h expected %h", bus.data_out, 16'h0001);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'hA5A5;
        vals[1] = 16'h5A5A;
        vals[2] = 16'h0F0F;
        bus.load = 1'b1;
        bus.mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = vals[i];
            step();
            n_checks++;
            if (bus.data_out !== vals[i]) begin
                $display("FAIL back_to_back%0d: got %h expected %h", i, bus.data_out, vals[i]);
                n_errors++;
            end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        bus.load    = 1'b0;
        bus.mode    = 1'b1;
        bus.data_in = 16'h0000;
        test_reset();
        test_load();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_mode_switch();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/modport_counter.md
MODPORT_COUNTER -- requirements
Module: modport_counter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge except reset.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have port data_in, input, 16 bits: parallel load value.
REQ-004 The block SHALL have port load, input, 1 bit: 1 = load data_in on the next rising clk edge.
REQ-005 The block SHALL have port mode, input, 1 bit: count direction; 1 = up, 0 = down.
REQ-006 The block SHALL have port data_out, output, 16 bits: current count, driven directly from a register with no combinational path from inputs.
REQ-007 The block SHALL have no parameters; the width is fixed at 16 bits.

Function
REQ-008 The block SHALL hold one 16-bit count register that drives data_out.
REQ-009 On each rising clk edge with reset=1 and load=1, the count SHALL become data_in; mode is ignored in that cycle.
REQ-010 On each rising clk edge with reset=1, load=0 and mode=1, the count SHALL become count+1, modulo 2^16.
REQ-011 On each rising clk edge with reset=1, load=0 and mode=0, the count SHALL become count-1, modulo 2^16.
REQ-012 Priority SHALL be, highest first: reset, then load, then count.
REQ-013 Latency SHALL be one clock: inputs sampled at edge N are reflected on data_out after edge N.
REQ-014 Up-count wrap: 16'hFFFF +1 SHALL give 16'h0000, with no stall or flag.
REQ-015 Down-count wrap: 16'h0000 -1 SHALL give 16'hFFFF.
REQ-016 The count SHALL change every enabled cycle; there is no hold mode, so the counter never idles while reset=1.
REQ-017 A mode change SHALL take effect at the first edge where it is sampled, with no extra pipeline cycle.
REQ-018 Load and count arithmetic SHALL be unsigned; no carry or borrow output exists.

Reset
REQ-019 When reset falls to 0, data_out SHALL become 16'h0000 immediately, without waiting for a clk edge.
REQ-020 While reset=0, data_out SHALL stay 16'h0000 regardless of load, mode, data_in or clk.
REQ-021 Reset SHALL be released by reset rising to 1; the first change after release happens at the next rising clk edge.
REQ-022 Reset asserted mid-count or mid-load SHALL abort the operation and clear the count; no pending load survives reset.

Verification
REQ-023 Reset then count up:
- Stimulus: reset=0, then release with load=0, mode=1, and run 3 edges.
- Required response: data_out = 0 during reset, then 1, 2, 3.
REQ-024 Load:
- Stimulus: load=1, data_in=16'h1234 for 1 edge, then load=0, mode=0 for 2 edges.
- Required response: data_out = 16'h1234, 16'h1233, 16'h1232.
REQ-025 Wrap up:
- Stimulus: load 16'hFFFE, then mode=1 for 2 edges.
- Required response: data_out = 16'hFFFF, then 16'h0000.
REQ-026 Wrap down:
- Stimulus: load 16'h0001, then mode=0 for 2 edges.
- Required response: data_out = 16'h0000, then 16'hFFFF.
REQ-027 Load priority:
- Stimulus: load=1, mode=1, data_in=16'h00A0 at one edge.
- Required response: data_out = 16'h00A0, not count+1.
REQ-028 Asynchronous reset mid-operation:
- Stimulus: counting at 16'h5555, then reset driven to 0 between clk edges.
- Required response: data_out = 16'h0000 before the next edge; after release with mode=1, the first edge gives 16'h0001.
